// File: rtl/inputdeserdes_align_if.sv
// Bundle between the IDDR front end, the word aligner and the TMDS decoder.
// The aligner sits on the slave side; the source/sink of the link is the master.
interface inputdeserdes_align_if;
    logic       din_r;
    logic       din_f;
    logic       realign;
    logic [9:0] pdatain;
    logic       pvalid;
    logic       locked;
    logic       token_det;
    logic [3:0] bitslip_cnt;

    modport master (
        output din_r, din_f, realign,
        input  pdatain, pvalid, locked, token_det, bitslip_cnt
    );

    modport slave (
        input  din_r, din_f, realign,
        output pdatain, pvalid, locked, token_det, bitslip_cnt
    );
endinterface

// File: rtl/inputdeserdes_align.sv
// TMDS receive word aligner: assembles IDDR bit pairs LSB-first into 10-bit words
// and bit-slips the word boundary until a run of control tokens is seen.
module inputdeserdes_align #(
    parameter int KPARALLELWIDTH = 10,
    parameter int TOKEN_CNT      = 8,
    parameter int SEARCH_WIN     = 64,
    parameter int LOSS_WIN       = 4096
) (
    input logic                 serialclk,
    input logic                 rstn,
    inputdeserdes_align_if.slave bus
);

    localparam int W = KPARALLELWIDTH;
    localparam logic [3:0]  RUN_LOCK = 4'(TOKEN_CNT);
    localparam logic [6:0]  WIN_END  = 7'(SEARCH_WIN);
    localparam logic [12:0] GAP_LOSS = 13'(LOSS_WIN);

    typedef enum logic {HUNT, LOCKED} state_t;

    function automatic logic is_token(input logic [W-1:0] w);
        return (w == 10'b1101010100) || (w == 10'b0010101011) ||
               (w == 10'b0101010100) || (w == 10'b1010101011);
    endfunction

    state_t       state;
    logic [19:0]  hist_p0;
    logic [2:0]   mod5;
    logic [3:0]   off;
    logic [3:0]   run;
    logic [6:0]   win;
    logic [12:0]  gap;
    logic [W-1:0] data_p1;
    logic         vld_p1;
    logic         tok_p1;
    logic         locked_p1;

    logic [19:0]  nh;
    logic [4:0]   off_idx;
    logic [W-1:0] word;
    logic         tok;
    logic         word_end;
    logic [3:0]   run_nx;
    logic [6:0]   win_nx;
    logic [12:0]  gap_nx;

    // Stage p0: newest pair enters at the top, oldest bit lives in bit 0
    always_comb begin
        nh       = {bus.din_f, bus.din_r, hist_p0[19:2]};
        off_idx  = {1'b0, off};
        word     = nh[off_idx +: W];
        tok      = is_token(word);
        word_end = (mod5 == 3'd4);
        run_nx   = tok ? run + 4'd1 : 4'd0;
        win_nx   = win + 7'd1;
        gap_nx   = tok ? 13'd0 : gap + 13'd1;
    end

    // Stage p1: word strobe, token flag and the per-word alignment FSM
    always_ff @(posedge serialclk or negedge rstn) begin
        if (!rstn) begin
            state     <= HUNT;
            hist_p0   <= '0;
            mod5      <= '0;
            off       <= '0;
            run       <= '0;
            win       <= '0;
            gap       <= '0;
            data_p1   <= '0;
            vld_p1    <= 1'b0;
            tok_p1    <= 1'b0;
            locked_p1 <= 1'b0;
        end else begin
            hist_p0 <= nh;
            mod5    <= word_end ? 3'd0 : mod5 + 3'd1;
            vld_p1  <= word_end;
            if (word_end) begin
                data_p1 <= word;
                tok_p1  <= tok;
            end

            // realign overrides whatever the current word would have decided
            if (bus.realign) begin
                state     <= HUNT;
                locked_p1 <= 1'b0;
                run       <= '0;
                win       <= '0;
                gap       <= '0;
            end else if (word_end) begin
                case (state)
                    HUNT: begin
                        if (run_nx == RUN_LOCK) begin
                            state     <= LOCKED;
                            locked_p1 <= 1'b1;
                            run       <= '0;
                            win       <= '0;
                            gap       <= '0;
                        end else if (win_nx == WIN_END) begin
                            off <= (off == 4'd9) ? 4'd0 : off + 4'd1;
                            run <= '0;
                            win <= '0;
                        end else begin
                            run <= run_nx;
                            win <= win_nx;
                        end
                    end
                    LOCKED: begin
                        if (gap_nx == GAP_LOSS) begin
                            state     <= HUNT;
                            locked_p1 <= 1'b0;
                            run       <= '0;
                            win       <= '0;
                            gap       <= '0;
                        end else begin
                            gap <= gap_nx;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign bus.pdatain     = data_p1;
    assign bus.pvalid      = vld_p1;
    assign bus.token_det   = tok_p1;
    assign bus.locked      = locked_p1;
    assign bus.bitslip_cnt = off;

endmodule

// File: tb/tb_inputdeserdes_align.sv
// Directed bench for inputdeserdes_align: reset, aligned lock, slip hunt, loss of lock,
// realign and payload round trip, with hand-derived word indices.
module tb_inputdeserdes_align;

    localparam logic [9:0] TOK  = 10'b1101010100;
    localparam logic [9:0] IDLE = 10'h1F0;

    logic serialclk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;
    int   npv    = 0;
    int   gap_c  = 0;
    bit   q[$];

    inputdeserdes_align_if bus ();

    inputdeserdes_align dut (
        .serialclk (serialclk),
        .rstn      (rstn),
        .bus       (bus)
    );

    always #5 serialclk = ~serialclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (word %0d)", tag, obs, exp, npv);
        end
    endtask

    task automatic push_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) q.push_back(w[i]);
    endtask

    // one serialclk: drive the next bit pair, sample outputs on the falling edge
    task automatic cycle();
        bus.din_r = (q.size() > 0) ? q.pop_front() : 1'b0;
        bus.din_f = (q.size() > 0) ? q.pop_front() : 1'b0;
        @(negedge serialclk);
    endtask

    task automatic wait_pvalid();
        int c;
        c = 0;
        do begin
            cycle();
            c++;
        end while (bus.pvalid !== 1'b1 && c < 8);
        check("pvalid_seen", 32'(bus.pvalid), 32'd1);
        gap_c = c;
        npv++;
    endtask

    task automatic do_reset();
        rstn        = 1'b0;
        bus.din_r   = 1'b0;
        bus.din_f   = 1'b0;
        bus.realign = 1'b0;
        q.delete();
        repeat (2) @(negedge serialclk);
        rstn = 1'b1;
        npv  = 0;
    endtask

    initial begin
        rstn        = 1'b1;
        bus.din_r   = 1'b0;
        bus.din_f   = 1'b0;
        bus.realign = 1'b0;
        #2 rstn = 1'b0;

        // 1: held in reset while the inputs toggle
        for (int i = 0; i < 12; i++) begin
            bus.din_r = i[0];
            bus.din_f = ~i[0];
            @(negedge serialclk);
            check("rst_pvalid", 32'(bus.pvalid), 32'd0);
        end
        check("rst_pdatain", 32'(bus.pdatain), 32'd0);
        check("rst_locked", 32'(bus.locked), 32'd0);
        check("rst_token", 32'(bus.token_det), 32'd0);
        check("rst_bitslip", 32'(bus.bitslip_cnt), 32'd0);

        // 2: aligned token stream; first strobe carries the zeroed history
        do_reset();
        for (int i = 0; i < 14; i++) push_word(TOK);
        for (int n = 1; n <= 12; n++) begin
            wait_pvalid();
            check("t2_spacing", 32'(gap_c), 32'd5);
            check("t2_locked", 32'(bus.locked), 32'(n >= 9));
            check("t2_bitslip", 32'(bus.bitslip_cnt), 32'd0);
            if (n >= 2) begin
                check("t2_pdatain", 32'(bus.pdatain), 32'(TOK));
                check("t2_token", 32'(bus.token_det), 32'd1);
            end else begin
                check("t2_first_word", 32'(bus.pdatain), 32'd0);
            end
        end

        // 3..6 share one stream: 3 junk bits, then word j is extracted at strobe j+2 once off=3
        do_reset();
        repeat (3) q.push_back(1'b0);
        for (int i = 0; i < 201; i++)  push_word(TOK);
        for (int i = 0; i < 4095; i++) push_word(IDLE);
        push_word(TOK);
        for (int i = 0; i < 4096; i++) push_word(IDLE);
        for (int i = 0; i < 25; i++)   push_word(TOK);
        push_word(10'h2AB);
        push_word(10'h0F3);
        push_word(IDLE);
        push_word(IDLE);

        for (int n = 1; n <= 200; n++) begin
            wait_pvalid();
            check("t3_bitslip", 32'(bus.bitslip_cnt), 32'(n / 64));
            check("t3_locked", 32'(bus.locked), 32'(n == 200));
        end
        check("t3_pdatain", 32'(bus.pdatain), 32'(TOK));
        check("t3_token", 32'(bus.token_det), 32'd1);

        // 4: 4095 idles + token keeps lock; 4096 idles drops it at strobe 8394
        for (int n = 201; n <= 8394; n++) begin
            wait_pvalid();
            check("t4_locked", 32'(bus.locked), 32'(n < 8394));
            if (n == 4297) begin
                check("t4_idle_word", 32'(bus.pdatain), 32'(IDLE));
                check("t4_idle_token", 32'(bus.token_det), 32'd0);
            end
            if (n == 4298) begin
                check("t4_tok_word", 32'(bus.pdatain), 32'(TOK));
                check("t4_tok_token", 32'(bus.token_det), 32'd1);
            end
        end
        check("t4_bitslip", 32'(bus.bitslip_cnt), 32'd3);

        // 5: relock at same offset, then realign on a token strobe
        for (int n = 8395; n <= 8404; n++) begin
            wait_pvalid();
            check("t5_relock", 32'(bus.locked), 32'(n >= 8402));
        end
        repeat (4) cycle();
        check("t5_no_strobe", 32'(bus.pvalid), 32'd0);
        bus.realign = 1'b1;
        cycle();
        bus.realign = 1'b0;
        npv++;
        check("t5_ra_pvalid", 32'(bus.pvalid), 32'd1);
        check("t5_ra_token", 32'(bus.token_det), 32'd1);
        check("t5_ra_locked", 32'(bus.locked), 32'd0);
        for (int n = 8406; n <= 8419; n++) begin
            wait_pvalid();
            check("t5_after_ra", 32'(bus.locked), 32'(n >= 8413));
            check("t5_bitslip", 32'(bus.bitslip_cnt), 32'd3);
        end

        // 6: payload words pass through unchanged (0x2AB is itself a control token)
        wait_pvalid();
        check("t6_w0_data", 32'(bus.pdatain), 32'h2AB);
        check("t6_w0_token", 32'(bus.token_det), 32'd1);
        check("t6_w0_locked", 32'(bus.locked), 32'd1);
        wait_pvalid();
        check("t6_w1_data", 32'(bus.pdatain), 32'h0F3);
        check("t6_w1_token", 32'(bus.token_det), 32'd0);
        check("t6_w1_locked", 32'(bus.locked), 32'd1);
        check("t6_bitslip", 32'(bus.bitslip_cnt), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
